// File: rtl/cpu_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mem_loader
// Purpose : Streams a program into a 16x8 memory while holding CPU2 in reset,
//           then serves as the CPU's async-read / sync-write memory port.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_mem_loader #(
    parameter int DW         = 8,
    parameter int AW         = 4,
    parameter int DEPTH      = 16,
    parameter int RESET_HOLD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          start_load,
    output logic          cpu_reset,
    input  logic [AW-1:0] address,
    input  logic          write,
    input  logic          read,
    input  logic [DW-1:0] memoryIn,
    output logic [DW-1:0] memoryOut,
    output logic [AW:0]   load_count,
    output logic          loaded
);

    localparam int              c_HW        = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(RESET_HOLD - 1);
    localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);
    localparam logic [AW-1:0]   c_WPTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   c_WPTR_ONE  = AW'(1);
    localparam logic [AW:0]     c_COUNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]     c_COUNT_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_count;
    logic [c_HW-1:0] r_hold;
    logic [DW-1:0]   r_mem [DEPTH];

    logic w_accept;
    logic w_load_done;
    logic w_cpu_wr;
    logic w_restart;
    logic w_unused_read;

    // The read strobe carries no function: reads are purely combinational.
    assign w_unused_read = read;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        load_ready  = 1'b0;
        cpu_reset   = 1'b1;
        loaded      = 1'b0;
        w_accept    = 1'b0;
        w_load_done = 1'b0;
        w_cpu_wr    = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_LOAD;
            end
            S_LOAD: begin
                load_ready  = 1'b1;
                w_accept    = load_valid;
                // A full memory ends the load even without load_last.
                w_load_done = load_valid && (load_last || (r_wptr == c_WPTR_LAST));
                if (w_load_done) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold == c_HOLD_LAST) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                cpu_reset = 1'b0;
                loaded    = 1'b1;
                w_cpu_wr  = write;
                w_restart = start_load;
                if (start_load) begin
                    w_next = S_LOAD;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_accept) begin
                if (r_wptr != c_WPTR_LAST) begin
                    r_wptr <= r_wptr + c_WPTR_ONE;
                end
                if (r_count != c_COUNT_MAX) begin
                    r_count <= r_count + c_COUNT_ONE;
                end
            end
            if (w_restart) begin
                r_wptr  <= '0;
                r_count <= '0;
            end
            if (r_state == S_HOLD) begin
                r_hold <= r_hold + c_HOLD_ONE;
            end else begin
                r_hold <= '0;
            end
        end
    end

    // Loader and CPU writes are never enabled in the same state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_wptr] <= load_data;
        end else if (w_cpu_wr) begin
            r_mem[address] <= memoryIn;
        end
    end

    assign memoryOut  = r_mem[address];
    assign load_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mem_loader
// Purpose : Self-checking bench for cpu_mem_loader against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_mem_loader;

    localparam int DW         = 8;
    localparam int AW         = 4;
    localparam int DEPTH      = 16;
    localparam int RESET_HOLD = 2;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          start_load = 1'b0;
    logic          cpu_reset;
    logic [AW-1:0] address = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] memoryIn = '0;
    logic [DW-1:0] memoryOut;
    logic [AW:0]   load_count;
    logic          loaded;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase, load position, byte count, hold countdown, memory.
    int         m_phase = P_IDLE;
    int         m_wptr = 0;
    int         m_count = 0;
    int         m_hold_left = 0;
    logic [7:0] m_mem [DEPTH];

    cpu_mem_loader #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RESET_HOLD(RESET_HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .start_load(start_load), .cpu_reset(cpu_reset),
        .address(address), .write(write), .read(read), .memoryIn(memoryIn),
        .memoryOut(memoryOut), .load_count(load_count), .loaded(loaded)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance the model by one edge using the currently driven inputs, then clock the DUT.
    task automatic step();
        if (!reset) begin
            m_phase = P_IDLE;
            m_wptr  = 0;
            m_count = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        end else begin
            case (m_phase)
                P_IDLE: m_phase = P_LOAD;
                P_LOAD: if (load_valid) begin
                    m_mem[m_wptr] = load_data;
                    m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
                    if (load_last || m_wptr == DEPTH - 1) begin
                        m_phase     = P_HOLD;
                        m_hold_left = RESET_HOLD;
                    end
                    if (m_wptr < DEPTH - 1) m_wptr = m_wptr + 1;
                end
                P_HOLD: begin
                    m_hold_left = m_hold_left - 1;
                    if (m_hold_left == 0) m_phase = P_RUN;
                end
                default: begin
                    if (write) m_mem[address] = memoryIn;
                    if (start_load) begin
                        m_phase = P_LOAD;
                        m_wptr  = 0;
                        m_count = 0;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        load_last  = 1'b0;
        start_load = 1'b0;
        write      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", load_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %0b expected 1", cpu_reset); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %0b expected 0", loaded); end
        checks++; if (load_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", load_count); end
        for (int a = 0; a < DEPTH; a++) begin
            address = AW'(a);
            #1;
            checks++; if (memoryOut !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d]: got %02h expected 00", a, memoryOut); end
        end
        reset = 1'b1;
        step();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b expected 1", load_ready); end
    endtask

    task automatic test_division_load();
        logic [7:0] prog [7];
        prog = '{8'h00, 8'h36, 8'h56, 8'h06, 8'h00, 8'h0A, 8'h05};
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == 6);
            #1;
            checks++; if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL div_loading[%0d]: got ready=%0b cpu_reset=%0b expected 1/1", i, load_ready, cpu_reset); end
            step();
        end
        idle_inputs();
        checks++; if (load_count !== 5'd7) begin errors++; $display("FAIL div_count: got %0d expected 7", load_count); end
        checks++; if (load_ready !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL div_after_last: got ready=%0b cpu_reset=%0b expected 0/1", load_ready, cpu_reset); end
        step();
        checks++; if (cpu_reset !== 1'b1 || loaded !== 1'b0) begin errors++; $display("FAIL div_hold1: got cpu_reset=%0b loaded=%0b expected 1/0", cpu_reset, loaded); end
        step();
        checks++; if (cpu_reset !== 1'b0 || loaded !== 1'b1) begin errors++; $display("FAIL div_run: got cpu_reset=%0b loaded=%0b expected 0/1", cpu_reset, loaded); end
        address = 4'd6;
        #1;
        checks++; if (memoryOut !== 8'h05) begin errors++; $display("FAIL div_mem6: got %02h expected 05", memoryOut); end
        address = 4'd1;
        #1;
        checks++; if (memoryOut !== 8'h36) begin errors++; $display("FAIL div_mem1: got %02h expected 36", memoryOut); end
    endtask

    task automatic test_cpu_write();
        address  = 4'd6;
        memoryIn = 8'h02;
        write    = 1'b1;
        #1;
        checks++; if (memoryOut !== 8'h05) begin errors++; $display("FAIL cpuwr_before: got %02h expected 05", memoryOut); end
        step();
        write = 1'b0;
        #1;
        checks++; if (memoryOut !== 8'h02) begin errors++; $display("FAIL cpuwr_mem6: got %02h expected 02", memoryOut); end
        address = 4'd5;
        #1;
        checks++; if (memoryOut !== 8'h0A) begin errors++; $display("FAIL cpuwr_mem5: got %02h expected 0A", memoryOut); end
    endtask

    task automatic test_load_gaps();
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        checks++; if (load_ready !== 1'b1 || cpu_reset !== 1'b1 || loaded !== 1'b0 || load_count !== 5'd0) begin
            errors++; $display("FAIL gap_restart: got ready=%0b cpu_reset=%0b loaded=%0b count=%0d expected 1/1/0/0", load_ready, cpu_reset, loaded, load_count);
        end
        write    = 1'b1;
        address  = 4'd3;
        memoryIn = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 8'hC0 + 8'(i);
            step();
        end
        load_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            step();
            checks++; if (load_count !== 5'd2 || memoryOut !== 8'h06) begin
                errors++; $display("FAIL gap_cycle[%0d]: got count=%0d mem3=%02h expected 2/06", g, load_count, memoryOut);
            end
        end
        load_valid = 1'b1;
        load_data  = 8'hC2;
        load_last  = 1'b1;
        step();
        idle_inputs();
        checks++; if (load_count !== 5'd3) begin errors++; $display("FAIL gap_count: got %0d expected 3", load_count); end
        for (int a = 0; a < 4; a++) begin
            address = AW'(a);
            #1;
            checks++; if (memoryOut !== ((a == 3) ? 8'h06 : 8'hC0 + 8'(a))) begin
                errors++; $display("FAIL gap_mem[%0d]: got %02h expected %02h", a, memoryOut, (a == 3) ? 8'h06 : 8'hC0 + 8'(a));
            end
        end
        step();
        step();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL gap_run: got loaded=%0b expected 1", loaded); end
    endtask

    task automatic test_overflow();
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        for (int i = 0; i < 17; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h10 + 8'(i);
            #1;
            checks++; if (load_ready !== (i < 16)) begin errors++; $display("FAIL ovf_ready[%0d]: got %0b expected %0b", i, load_ready, (i < 16)); end
            step();
        end
        idle_inputs();
        checks++; if (load_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", load_count); end
        step();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL ovf_run: got loaded=%0b expected 1", loaded); end
        for (int a = 0; a < DEPTH; a++) begin
            address = AW'(a);
            #1;
            checks++; if (memoryOut !== 8'h10 + 8'(a)) begin errors++; $display("FAIL ovf_mem[%0d]: got %02h expected %02h", a, memoryOut, 8'h10 + 8'(a)); end
        end
    endtask

    task automatic test_reset_midload();
        start_load = 1'b1;
        step();
        start_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h31 + 8'(i);
            step();
        end
        load_data = 8'h35;
        reset     = 1'b0;
        step();
        idle_inputs();
        checks++; if (load_count !== 5'd0 || cpu_reset !== 1'b1 || load_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_state: got count=%0d cpu_reset=%0b ready=%0b expected 0/1/0", load_count, cpu_reset, load_ready);
        end
        for (int a = 0; a < DEPTH; a++) begin
            address = AW'(a);
            #1;
            checks++; if (memoryOut !== 8'h00) begin errors++; $display("FAIL midrst_mem[%0d]: got %02h expected 00", a, memoryOut); end
        end
        reset = 1'b1;
        step();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: got ready=%0b expected 1", load_ready); end
    endtask

    task automatic test_start_with_write();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h41 + 8'(i);
            load_last  = (i == 2);
            step();
        end
        idle_inputs();
        for (int i = 0; i < RESET_HOLD; i++) step();
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL sw_run: got loaded=%0b expected 1", loaded); end
        start_load = 1'b1;
        write      = 1'b1;
        address    = 4'd2;
        memoryIn   = 8'h77;
        step();
        idle_inputs();
        checks++; if (cpu_reset !== 1'b1 || load_ready !== 1'b1 || loaded !== 1'b0 || load_count !== 5'd0) begin
            errors++; $display("FAIL sw_restart: got cpu_reset=%0b ready=%0b loaded=%0b count=%0d expected 1/1/0/0", cpu_reset, load_ready, loaded, load_count);
        end
        #1;
        checks++; if (memoryOut !== 8'h77) begin errors++; $display("FAIL sw_mem2_write: got %02h expected 77", memoryOut); end
        load_valid = 1'b1;
        load_data  = 8'hAA;
        step();
        load_data  = 8'hBB;
        load_last  = 1'b1;
        step();
        idle_inputs();
        checks++; if (load_count !== 5'd2) begin errors++; $display("FAIL sw_count: got %0d expected 2", load_count); end
        for (int a = 0; a < 3; a++) begin
            address = AW'(a);
            #1;
            checks++; if (memoryOut !== ((a == 0) ? 8'hAA : (a == 1) ? 8'hBB : 8'h77)) begin
                errors++; $display("FAIL sw_mem[%0d]: got %02h expected %02h", a, memoryOut, (a == 0) ? 8'hAA : (a == 1) ? 8'hBB : 8'h77);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            reset      = ($urandom_range(0, 99) != 0);
            load_valid = ($urandom_range(0, 9) < 7);
            load_data  = 8'($urandom);
            load_last  = ($urandom_range(0, 99) < 15);
            start_load = ($urandom_range(0, 99) < 6);
            write      = ($urandom_range(0, 9) < 3);
            read       = ~write;
            address    = AW'($urandom);
            memoryIn   = 8'($urandom);
            #1;
            checks++; if (load_ready !== (m_phase == P_LOAD)) begin errors++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", c, load_ready, (m_phase == P_LOAD)); end
            checks++; if (cpu_reset !== (m_phase != P_RUN)) begin errors++; $display("FAIL rnd_cpu_reset[%0d]: got %0b expected %0b", c, cpu_reset, (m_phase != P_RUN)); end
            checks++; if (loaded !== (m_phase == P_RUN)) begin errors++; $display("FAIL rnd_loaded[%0d]: got %0b expected %0b", c, loaded, (m_phase == P_RUN)); end
            checks++; if (load_count !== 5'(m_count)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, load_count, m_count); end
            checks++; if (memoryOut !== m_mem[address]) begin errors++; $display("FAIL rnd_mem[%0d] addr %0d: got %02h expected %02h", c, address, memoryOut, m_mem[address]); end
            step();
        end
        reset = 1'b1;
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            address = AW'(a);
            #1;
            checks++; if (memoryOut !== m_mem[a]) begin errors++; $display("FAIL rnd_final_mem[%0d]: got %02h expected %02h", a, memoryOut, m_mem[a]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        test_reset();
        test_division_load();
        test_cpu_write();
        test_load_gaps();
        test_overflow();
        test_reset_midload();
        test_start_with_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_mem_loader.md
# cpu_mem_loader

Program loader and 16×8 data/instruction memory for the CPU2 accumulator core. It accepts a byte stream over a valid/ready handshake and writes it sequentially into memory while holding the CPU in reset. It then releases the CPU and serves as its memory port: asynchronous read, synchronous write. It sits directly upstream of CPU2 and replaces the behavioural memory array used around the core.

## Interface
- DW, 8, data/instruction width
- AW, 4, address width
- DEPTH, 16, memory words (2^AW)
- RESET_HOLD, 2, cycles the CPU is held in reset after loading ends (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low block reset
- load_valid  in  1  load byte present
- load_data  in  DW  load byte
- load_last  in  1  qualifies the final byte of the program
- load_ready  out  1  loader accepts a byte this cycle
- start_load  in  1  pulse in RUN: re-enter LOAD
- cpu_reset  out  1  active-high reset to CPU2
- address  in  AW  CPU address
- write  in  1  CPU write strobe
- read  in  1  CPU read strobe (informational; read is always combinational)
- memoryIn  in  DW  CPU write data
- memoryOut  out  DW  mem[address], combinational
- load_count  out  AW+1  bytes written by the last/current load
- loaded  out  1  high in RUN

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- Reset (reset==0 at an edge) puts the block in IDLE and clears all memory words to 0. It also sets load_ready=0, cpu_reset=1, load_count=0, loaded=0, write pointer wptr=0, and the hold counter to 0. This applies in any state, including mid-load and mid-run.
- IDLE: unconditionally → LOAD next cycle.
- LOAD: load_ready=1, cpu_reset=1.
  - On load_valid&&load_ready: mem[wptr]<=load_data, wptr+1, load_count+1.
  - Terminate → HOLD if load_last is set on the accepted byte, or if wptr==DEPTH-1 (16th byte).
  - Bytes without load_valid are not written.
- HOLD: load_ready=0, cpu_reset=1. Counts RESET_HOLD cycles, then → RUN.
- RUN: cpu_reset=0, loaded=1, load_ready=0.
  - write==1 at an edge: mem[address]<=memoryIn.
  - start_load==1: → LOAD with wptr=0 and load_count=0. Memory is not cleared, and cpu_reset rises next cycle.
- CPU write/address are ignored (no memory update) in IDLE, LOAD and HOLD.
- start_load is ignored outside RUN.
- A write and start_load in the same RUN cycle: the write is performed, and the transition happens on the same edge.
- load_valid in HOLD/RUN is ignored; no write occurs and load_count is unchanged.
- memoryOut=mem[address] in all states. Loader writes are visible on the cycle after the edge.
- No wrap: wptr never exceeds DEPTH-1, and load_count saturates at DEPTH.

## Timing
- Reset release → LOAD (load_ready=1) after 1 cycle (IDLE).
- Byte accepted on the edge where load_valid&&load_ready. Throughput is 1 byte/cycle.
- The last byte is accepted at edge T. Timeline from there:
  - load_ready=0 from T.
  - cpu_reset falls and loaded rises after RESET_HOLD further edges, i.e. visible after edge T+RESET_HOLD.
- start_load at edge T: cpu_reset=1, loaded=0, load_ready=1 after T.
- CPU write latency is 1 edge. Read is 0-latency combinational.

## Test plan
- Load the division program 0x00,0x36,0x56,0x06,0x00,0x0A,0x05, with load_last on the 7th byte → load_count=7. cpu_reset=1 throughout, then falls 2 cycles after the last accept. In RUN, address=6 → memoryOut=0x05, and address=1 → 0x36.
- In RUN: write=1, address=6, memoryIn=0x02 → next cycle memoryOut=0x02 at address 6, and mem[5] still 0x0A.
- Stream 17 bytes 0x10..0x20 with load_last never set → 16 accepted, load_count=16, mem[15]=0x1F, HOLD entered. The 17th byte (0x20) is not accepted (load_ready=0), and no address is overwritten.
- During LOAD: write=1, address=3, memoryIn=0xFF → mem[3] unchanged. Drop load_valid for 3 cycles mid-stream → no extra writes, and load_count is unchanged across the gap.
- Drive reset=0 after 4 bytes loaded → next cycle load_count=0, cpu_reset=1, mem[0..3]=0. One cycle after release, load_ready=1.
- In RUN: start_load together with write (address=2, data=0x77) → mem[2]=0x77, then LOAD with cpu_reset=1. Reload 2 bytes 0xAA,0xBB with last → mem[0..1]=AA,BB, mem[2]=0x77 retained, load_count=2.
